zero_window_sequencer: RTL
==========================

Name: zero_window_sequencer

Overview:
- Data-clock-domain controller that schedules the sample-zeroing gate for the user_logic1 ZERO datapath.
- On each accepted primary-trigger rising edge it plays a programmed list of up to NUM_WINDOWS (gap, length) windows and drives zero_active_o.
- The channel datapath substitutes zeros for sample data while zero_active_o is high.
- Table and control values arrive already synchronised into data_clk_i through the existing CDC path.

Parameters:
- NUM_WINDOWS, 4: number of window table entries; legal range 1..16.
- CNT_WIDTH, 32: width of gap values and of the internal gap/length counters.
- LEN_POW2_MAX, 24: maximum length exponent; larger programmed values saturate to this.

Ports:
- data_clk_i  in  1  data clock.
- data_resetn_i  in  1  asynchronous active-low reset.
- enable_i  in  1  sequencer enable.
- trig_i  in  1  one-cycle primary-trigger rising pulse.
- cfg_wr_i  in  1  table write strobe.
- cfg_idx_i  in  clog2(NUM_WINDOWS)  table entry index.
- cfg_ofs_i  in  CNT_WIDTH  gap in cycles before this window.
- cfg_len_pow2_i  in  7  window length exponent; length = 2^n cycles.
- cfg_num_i  in  clog2(NUM_WINDOWS+1)  number of active windows.
- zero_active_o  out  1  zeroing gate, registered.
- busy_o  out  1  sequence in progress.
- win_idx_o  out  clog2(NUM_WINDOWS)  index of the current window.
- done_o  out  1  one-cycle pulse after the last window ends.
- trig_miss_o  out  1  one-cycle pulse when a trigger is ignored while busy.
- cfg_reject_o  out  1  one-cycle pulse when a table write is dropped.

Behaviour:
- Reset:
  - Asynchronous on data_resetn_i low.
  - All outputs 0, state IDLE.
  - All table entries reset to ofs=0, len_pow2=0.
- Width rules:
  - Effective window count = min(cfg_num_i, NUM_WINDOWS).
  - cfg_len_pow2_i is saturated to LEN_POW2_MAX when the entry is written.
  - Length counter width is LEN_POW2_MAX+1 bits; no wrap occurs.
- States: IDLE, GAP, ZERO.
- IDLE:
  - Trigger accepted when trig_i=1, enable_i=1 and effective count >= 1.
  - On accept: win_idx=0 and busy_o=1 from the next cycle.
  - Trigger in cycle T with ofs[0]=G: zero_active_o is high in cycles T+1+G through T+G+2^len[0] inclusive.
  - If G=0, zero_active_o rises at T+1 (state goes directly to ZERO).
- GAP:
  - Counts ofs[idx] cycles with zero_active_o=0.
  - When the count is exhausted, moves to ZERO.
- ZERO:
  - Holds zero_active_o=1 for exactly 2^len[idx] cycles.
  - Then, if idx < count-1: idx increments. If the next ofs=0, zero_active_o stays high with no low cycle between windows; otherwise state goes to GAP.
  - On the last window's final zero cycle +1: zero_active_o=0, busy_o=0, done_o=1 for one cycle, state IDLE, win_idx_o=0.
- Table values are read when each window starts.
- Table writes:
  - Accepted only while busy_o=0.
  - A write with busy_o=1 is dropped and cfg_reject_o pulses one cycle later.
  - A write and an accepting trigger in the same cycle: the write takes effect first, and the trigger uses the new entry.
- enable_i falling while busy: abort next cycle; zero_active_o=0, busy_o=0, state IDLE, no done_o.
- trig_i while busy (without the retrigger option): ignored; trig_miss_o pulses the next cycle.
- trig_i coincident with the final zero cycle counts as busy, so it is missed.
- trig_i with effective count=0 or enable_i=0: ignored silently.
- Mid-operation reset: immediate return to the reset values.

Optional Feature:
- Macro: ZERO_WINDOW_SEQUENCER_RETRIG_EN.
- Defined:
  - trig_i while busy restarts the sequence at window 0 with the same timing as an IDLE accept.
  - zero_active_o goes low in the restart cycle unless ofs[0]=0.
  - trig_miss_o is tied 0.
- Undefined: triggers during busy are ignored and pulse trig_miss_o.

Test Plan:
1. Program cfg_num=1, ofs[0]=5, len_pow2[0]=3; trigger at cycle 10 -> zero_active_o high in cycles 16..23, done_o at cycle 24, busy_o 11..23.
2. cfg_num=2, ofs={0,0}, len={2,1}; trigger at T -> zero_active_o high continuously T+1..T+6, with win_idx_o changing 0->1 at T+5.
3. len_pow2=40 written with LEN_POW2_MAX=24 -> window length 2^24 cycles (check via the counter after 2^24 cycles, or with a reduced-parameter build LEN_POW2_MAX=4 giving 16 cycles).
4. Second trigger mid-window (macro undefined) -> trig_miss_o one pulse, timing unchanged; with the macro defined, the sequence restarts at the trigger cycle+1.
5. enable_i dropped during GAP of window 1 -> next cycle busy_o=0, zero_active_o=0, no done_o; cfg write while busy -> cfg_reject_o pulse and the table is unchanged on readback.
6. Assert data_resetn_i low mid-ZERO -> all outputs 0 immediately; after release, a trigger with the default table (ofs=0, len=0) and cfg_num=1 gives one zero cycle at T+1.

Source files
------------

// File: rtl/zero_window_sequencer.sv
// zero_window_sequencer
//   Data-clock-domain scheduler for the sample-zeroing gate. Each accepted
//   trigger plays up to NUM_WINDOWS programmed (gap, 2^n length) windows and
//   drives zero_active_o while a window is open.
//   Optional feature macro: ZERO_WINDOW_SEQUENCER_RETRIG_EN. When it is defined,
//   a trigger while busy restarts the sequence at window 0, and trig_miss_o
//   stays 0.
// Ports:
//   data_clk_i, data_resetn_i   clock, asynchronous active-low reset
//   enable_i, trig_i            sequencer enable, one-cycle trigger pulse
//   cfg_wr_i, cfg_idx_i,        table write strobe, entry index,
//   cfg_ofs_i, cfg_len_pow2_i   gap before the window, length exponent
//   cfg_num_i                   number of active windows
//   zero_active_o               registered zeroing gate
//   busy_o, win_idx_o           sequence in progress, current window index
//   done_o, trig_miss_o,        one-cycle pulses: sequence complete,
//   cfg_reject_o                trigger ignored, table write dropped
module zero_window_sequencer #(
  parameter int unsigned NUM_WINDOWS  = 4,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned LEN_POW2_MAX = 24,
  localparam int unsigned IDX_W = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1,
  localparam int unsigned NUM_W = $clog2(NUM_WINDOWS + 1)
) (
  input  logic                 data_clk_i,
  input  logic                 data_resetn_i,
  input  logic                 enable_i,
  input  logic                 trig_i,
  input  logic                 cfg_wr_i,
  input  logic [IDX_W-1:0]     cfg_idx_i,
  input  logic [CNT_WIDTH-1:0] cfg_ofs_i,
  input  logic [6:0]           cfg_len_pow2_i,
  input  logic [NUM_W-1:0]     cfg_num_i,
  output logic                 zero_active_o,
  output logic                 busy_o,
  output logic [IDX_W-1:0]     win_idx_o,
  output logic                 done_o,
  output logic                 trig_miss_o,
  output logic                 cfg_reject_o
);

  localparam int unsigned LP_W  = 7;
  localparam int unsigned LEN_W = LEN_POW2_MAX + 1;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_ZERO} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] tbl_ofs [NUM_WINDOWS];
  logic [LP_W-1:0]      tbl_len [NUM_WINDOWS];
  logic [CNT_WIDTH-1:0] gap_cnt;
  logic [LEN_W-1:0]     len_cnt;
  logic [LP_W-1:0]      cur_len;

  logic [NUM_W-1:0]     eff_cnt;
  logic [LP_W-1:0]      len_sat;
  logic [LP_W-1:0]      first_len;
  logic [LP_W-1:0]      nxt_len;
  logic [CNT_WIDTH-1:0] first_ofs;
  logic [CNT_WIDTH-1:0] nxt_ofs;
  logic [IDX_W-1:0]     nxt_idx;
  logic                 idx_ok;
  logic                 busy;
  logic                 wr_ok;
  logic                 start;
  logic                 abort;
  logic                 launch;
  logic                 last_win;

  // Remaining-cycle load value for a 2^e window (counter runs down to 0).
  function automatic logic [LEN_W-1:0] len_cycles(input logic [LP_W-1:0] e);
    return (LEN_W'(1) << e) - LEN_W'(1);
  endfunction

  // Decode of table access, window-0 bypass and sequencing decisions.
  always_comb begin
    eff_cnt   = (cfg_num_i > NUM_W'(NUM_WINDOWS)) ? NUM_W'(NUM_WINDOWS) : cfg_num_i;
    len_sat   = (cfg_len_pow2_i > LP_W'(LEN_POW2_MAX)) ? LP_W'(LEN_POW2_MAX) : cfg_len_pow2_i;
    idx_ok    = (32'(cfg_idx_i) < NUM_WINDOWS);
    busy      = (state != S_IDLE);
    wr_ok     = cfg_wr_i && !busy && idx_ok;

    // A write to entry 0 in the accept cycle must be seen by that trigger.
    first_ofs = tbl_ofs[0];
    first_len = tbl_len[0];
    if (wr_ok && (cfg_idx_i == '0)) begin
      first_ofs = cfg_ofs_i;
      first_len = len_sat;
    end

    nxt_idx = win_idx_o + IDX_W'(1);
    if (32'(nxt_idx) >= NUM_WINDOWS) begin
      nxt_idx = '0;
    end
    nxt_ofs  = tbl_ofs[nxt_idx];
    nxt_len  = tbl_len[nxt_idx];
    last_win = (NUM_W'(win_idx_o) + NUM_W'(1)) >= eff_cnt;

    start = trig_i && enable_i && (eff_cnt != '0);
    abort = busy && !enable_i;
`ifdef ZERO_WINDOW_SEQUENCER_RETRIG_EN
    launch = start;
`else
    launch = start && !busy;
`endif
  end

  // Sequencer FSM, window table and registered outputs.
  always_ff @(posedge data_clk_i or negedge data_resetn_i) begin
    if (!data_resetn_i) begin
      state         <= S_IDLE;
      zero_active_o <= 1'b0;
      busy_o        <= 1'b0;
      win_idx_o     <= '0;
      done_o        <= 1'b0;
      trig_miss_o   <= 1'b0;
      cfg_reject_o  <= 1'b0;
      gap_cnt       <= '0;
      len_cnt       <= '0;
      cur_len       <= '0;
      for (int i = 0; i < NUM_WINDOWS; i++) begin
        tbl_ofs[i] <= '0;
        tbl_len[i] <= '0;
      end
    end else begin
      done_o       <= 1'b0;
      trig_miss_o  <= 1'b0;
      cfg_reject_o <= cfg_wr_i && busy;

      if (wr_ok) begin
        tbl_ofs[cfg_idx_i] <= cfg_ofs_i;
        tbl_len[cfg_idx_i] <= len_sat;
      end

      if (abort) begin
        state         <= S_IDLE;
        zero_active_o <= 1'b0;
        busy_o        <= 1'b0;
        win_idx_o     <= '0;
      end else if (launch) begin
        busy_o    <= 1'b1;
        win_idx_o <= '0;
        cur_len   <= first_len;
        if (first_ofs == '0) begin
          state         <= S_ZERO;
          zero_active_o <= 1'b1;
          len_cnt       <= len_cycles(first_len);
        end else begin
          state         <= S_GAP;
          zero_active_o <= 1'b0;
          gap_cnt       <= first_ofs - CNT_WIDTH'(1);
        end
      end else begin
`ifndef ZERO_WINDOW_SEQUENCER_RETRIG_EN
        trig_miss_o <= busy && trig_i && enable_i;
`endif
        case (state)
          S_GAP: begin
            if (gap_cnt == '0) begin
              state         <= S_ZERO;
              zero_active_o <= 1'b1;
              len_cnt       <= len_cycles(cur_len);
            end else begin
              gap_cnt <= gap_cnt - CNT_WIDTH'(1);
            end
          end
          S_ZERO: begin
            if (len_cnt == '0) begin
              if (last_win) begin
                state         <= S_IDLE;
                zero_active_o <= 1'b0;
                busy_o        <= 1'b0;
                win_idx_o     <= '0;
                done_o        <= 1'b1;
              end else begin
                // Back-to-back windows keep the gate high with no low cycle.
                win_idx_o <= nxt_idx;
                cur_len   <= nxt_len;
                if (nxt_ofs == '0) begin
                  len_cnt <= len_cycles(nxt_len);
                end else begin
                  state         <= S_GAP;
                  zero_active_o <= 1'b0;
                  gap_cnt       <= nxt_ofs - CNT_WIDTH'(1);
                end
              end
            end else begin
              len_cnt <= len_cnt - LEN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
